// File: rtl/sonata_clkgen.sv
// Portable clock and reset generator: board clock passthrough, emulated PLL lock, synchronised rst_sys_n.
// Latency: locked rises after edge LockCycles+1 of reset release; rst_sys_n rises ResetSyncStages edges later.
// Backpressure: none; free-running generator. Optional power-on reset stretcher under `SONATA_CLKGEN_POR_EN.
module sonata_clkgen #(
  parameter int unsigned LockCycles      = 64,
  parameter int unsigned ResetSyncStages = 2
) (
  input  logic IO_CLK,
  input  logic IO_RST,
  output logic IO_CLK_BUF,
  output logic clk_sys,
  output logic locked,
  output logic rst_sys_n
);

  // Counter just wide enough to hold LockCycles without wrapping.
  localparam int unsigned CntW = $clog2(LockCycles + 1);
  localparam logic [CntW-1:0] LockMax = CntW'(LockCycles);

  // Out-of-range parameters would silently give a wrong lock time, so stop elaboration.
  if (LockCycles < 1 || LockCycles > 65535) begin : g_bad_lock_cycles
    $error("sonata_clkgen: LockCycles must be in 1..65535");
  end
  if (ResetSyncStages < 2) begin : g_bad_sync_stages
    $error("sonata_clkgen: ResetSyncStages must be at least 2");
  end

  // Generic build: both clocks are the board clock, no buffering primitive.
  assign IO_CLK_BUF = IO_CLK;
  assign clk_sys    = IO_CLK;

  // Effective reset seen by the lock counter and the release chain.
  logic rst_eff;

`ifdef SONATA_CLKGEN_POR_EN
  // Power-on counter; only configuration clears it, IO_RST deliberately does not.
  logic [7:0] por_cnt_q = 8'd0;
  logic [7:0] por_cnt_d;

  // Next power-on count: count up and stick at 255.
  always_comb begin
    por_cnt_d = por_cnt_q;
    if (por_cnt_q != 8'hFF) begin
      por_cnt_d = por_cnt_q + 8'd1;
    end
  end

  // Power-on counter register, free-running from configuration.
  always_ff @(posedge IO_CLK) begin
    por_cnt_q <= por_cnt_d;
  end

  // Short quiet window, then a forced reset stretch, then follow the external request.
  always_comb begin
    rst_eff = IO_RST;
    if (por_cnt_q < 8'd5) begin
      rst_eff = 1'b0;
    end else if (por_cnt_q < 8'd200) begin
      rst_eff = 1'b1;
    end
  end
`else
  assign rst_eff = IO_RST;
`endif

  // Lock emulation state; initial values cover the window before any reset edge.
  logic [CntW-1:0]            lock_cnt_q = '0;
  logic [CntW-1:0]            lock_cnt_d;
  logic                       locked_q   = 1'b0;
  logic                       locked_d;
  logic [ResetSyncStages-1:0] sync_q     = '0;
  logic [ResetSyncStages-1:0] sync_d;

  // Next-state: saturating lock counter, registered compare, shift lock into the release chain.
  always_comb begin
    lock_cnt_d = lock_cnt_q;
    if (lock_cnt_q != LockMax) begin
      lock_cnt_d = lock_cnt_q + CntW'(1);
    end
    locked_d = (lock_cnt_q == LockMax);
    sync_d   = {sync_q[ResetSyncStages-2:0], locked_q};
  end

  // State registers; reset clears everything at the sampling edge so rst_sys_n asserts with no delay.
  always_ff @(posedge IO_CLK) begin
    if (rst_eff) begin
      lock_cnt_q <= '0;
      locked_q   <= 1'b0;
      sync_q     <= '0;
    end else begin
      lock_cnt_q <= lock_cnt_d;
      locked_q   <= locked_d;
      sync_q     <= sync_d;
    end
  end

  assign locked    = locked_q;
  assign rst_sys_n = sync_q[ResetSyncStages-1];

endmodule

// File: tb/tb_sonata_clkgen.sv
// Directed bench for sonata_clkgen: default and small-parameter instances, optional power-on build.
// Latency under test: lock and release edge numbers counted from reset release.
// Backpressure: not applicable; all stimulus is cycle-counted with no open-ended waits.
module tb_sonata_clkgen;

  logic io_clk = 1'b0;
  logic io_rst  = 1'b1;
  logic io_rst1 = 1'b1;
  logic clk_buf0, clk_sys0, locked0, rst_n0;
  logic clk_buf1, clk_sys1, locked1, rst_n1;

  int checks   = 0;
  int failures = 0;

  always #5 io_clk = ~io_clk;

  sonata_clkgen dut (
    .IO_CLK     (io_clk),
    .IO_RST     (io_rst),
    .IO_CLK_BUF (clk_buf0),
    .clk_sys    (clk_sys0),
    .locked     (locked0),
    .rst_sys_n  (rst_n0)
  );

  sonata_clkgen #(.LockCycles(1), .ResetSyncStages(3)) dut1 (
    .IO_CLK     (io_clk),
    .IO_RST     (io_rst1),
    .IO_CLK_BUF (clk_buf1),
    .clk_sys    (clk_sys1),
    .locked     (locked1),
    .rst_sys_n  (rst_n1)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One active edge, then settle before sampling.
  task automatic tick();
    @(posedge io_clk);
    #1;
  endtask

  // Clock outputs against the board clock in both phases; consumes one active edge.
  task automatic clk_phase_checks(input string tag);
    @(negedge io_clk);
    #1;
    check_eq({tag, " buf0 low"}, clk_buf0, io_clk);
    check_eq({tag, " sys0 low"}, clk_sys0, io_clk);
    check_eq({tag, " buf1 low"}, clk_buf1, io_clk);
    check_eq({tag, " sys1 low"}, clk_sys1, io_clk);
    @(posedge io_clk);
    check_eq({tag, " buf0 edge"}, clk_buf0, 1'b1);
    check_eq({tag, " sys0 edge"}, clk_sys0, 1'b1);
    #1;
    check_eq({tag, " buf0 high"}, clk_buf0, io_clk);
    check_eq({tag, " sys0 high"}, clk_sys0, io_clk);
    check_eq({tag, " buf1 high"}, clk_buf1, io_clk);
    check_eq({tag, " sys1 high"}, clk_sys1, io_clk);
  endtask

  initial begin
    #1;
    check_eq("cfg locked0", locked0, 1'b0);
    check_eq("cfg rst_n0", rst_n0, 1'b0);

`ifdef SONATA_CLKGEN_POR_EN
    // IO_RST low from configuration; the power-on stretch alone drives the sequence.
    io_rst  = 1'b0;
    io_rst1 = 1'b0;
    for (int n = 1; n <= 299; n++) begin
      tick();
      check_eq($sformatf("por locked0 e%0d", n), locked0, (n >= 265));
      check_eq($sformatf("por rst_n0 e%0d", n), rst_n0, (n >= 267));
    end
    io_rst = 1'b1;
    tick();
    check_eq("por rst e300 locked0", locked0, 1'b0);
    check_eq("por rst e300 rst_n0", rst_n0, 1'b0);
    check_eq("por rst e300 por_cnt", dut.por_cnt_q, 8'd255);
    io_rst = 1'b0;
    for (int n = 1; n <= 3; n++) begin
      tick();
      check_eq($sformatf("por after e%0d por_cnt", n), dut.por_cnt_q, 8'd255);
      check_eq($sformatf("por after e%0d rst_n0", n), rst_n0, 1'b0);
    end
`else
    // Hold reset for five edges.
    for (int n = 1; n <= 5; n++) begin
      tick();
      check_eq($sformatf("rst e%0d locked0", n), locked0, 1'b0);
      check_eq($sformatf("rst e%0d rst_n0", n), rst_n0, 1'b0);
      check_eq($sformatf("rst e%0d locked1", n), locked1, 1'b0);
      check_eq($sformatf("rst e%0d rst_n1", n), rst_n1, 1'b0);
    end
    clk_phase_checks("clk in reset");

    // Release: lock after edge 65, reset release after edge 67, then 200 steady edges.
    io_rst = 1'b0;
    for (int k = 1; k <= 267; k++) begin
      tick();
      check_eq($sformatf("seq locked0 e%0d", k), locked0, (k >= 65));
      check_eq($sformatf("seq rst_n0 e%0d", k), rst_n0, (k >= 67));
    end
    clk_phase_checks("clk running");
    check_eq("steady locked0", locked0, 1'b1);
    check_eq("steady rst_n0", rst_n0, 1'b1);

    // Fresh reset, release, single-edge pulse at edge 100, then relock.
    io_rst = 1'b1;
    tick();
    check_eq("rerst locked0", locked0, 1'b0);
    check_eq("rerst rst_n0", rst_n0, 1'b0);
    io_rst = 1'b0;
    for (int k = 1; k <= 99; k++) begin
      tick();
      check_eq($sformatf("pre locked0 e%0d", k), locked0, (k >= 65));
      check_eq($sformatf("pre rst_n0 e%0d", k), rst_n0, (k >= 67));
    end
    io_rst = 1'b1;
    tick();
    check_eq("pulse locked0", locked0, 1'b0);
    check_eq("pulse rst_n0", rst_n0, 1'b0);
    io_rst = 1'b0;
    for (int k = 1; k <= 70; k++) begin
      tick();
      check_eq($sformatf("relock locked0 e%0d", k), locked0, (k >= 65));
      check_eq($sformatf("relock rst_n0 e%0d", k), rst_n0, (k >= 67));
    end

    // Small instance: LockCycles=1, ResetSyncStages=3.
    io_rst1 = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check_eq($sformatf("small locked1 e%0d", k), locked1, (k >= 2));
      check_eq($sformatf("small rst_n1 e%0d", k), rst_n1, (k >= 5));
    end
    io_rst1 = 1'b1;
    tick();
    check_eq("small rst locked1", locked1, 1'b0);
    check_eq("small rst rst_n1", rst_n1, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sonata_clkgen.md
Name: sonata_clkgen

Overview:
- Portable clock and reset generator for the Sonata system.
- Takes the board clock and an active-high synchronous reset request.
- Provides a buffered board clock, the system clock, an emulated PLL-lock indication and a synchronised active-low system reset (`rst_sys_n`) for sonata_system.
- In this generic build `clk_sys` is the board clock passed through. Lock timing is modelled by a counter.

Parameters:
- LockCycles, 64: cycles after reset release before `locked` asserts. Legal range 1..65535.
- ResetSyncStages, 2: flops in the `rst_sys_n` release synchroniser. Minimum 2.

Ports:
- IO_CLK  input  1  board clock (25 MHz); the only clock.
- IO_RST  input  1  reset request; synchronous, active-high, sampled on `IO_CLK` rising edge.
- IO_CLK_BUF  output  1  buffered board clock, equal to `IO_CLK`.
- clk_sys  output  1  system clock, equal to `IO_CLK` in the generic build.
- locked  output  1  emulated PLL lock.
- rst_sys_n  output  1  system reset, active-low, deasserts synchronously.

Behaviour:
- Clocks:
  - `IO_CLK_BUF = IO_CLK` and `clk_sys = IO_CLK`, combinational.
  - No logic is clocked on any other clock.
- Effective reset `rst_eff`:
  - Without the optional feature, `rst_eff = IO_RST`.
  - With the optional feature, see the Optional Feature section.
- Reset (`rst_eff` = 1 at an edge): at that edge `lock_cnt` ← 0, `locked` ← 0, and every synchroniser flop ← 0, so `rst_sys_n` = 0.
- Reset values: `locked` = 0, `rst_sys_n` = 0, `lock_cnt` = 0. The same values are required at configuration via initial values.
- Lock counter:
  - Width is clog2(LockCycles+1).
  - Increments by 1 on each edge with `rst_eff` = 0 and saturates at LockCycles; no wrap.
- Lock output:
  - `locked` is registered: `locked` ← (`lock_cnt` == LockCycles).
  - Edge 1 is the first edge with `rst_eff` = 0. `locked` goes high after edge LockCycles+1.
- Reset release:
  - `locked` shifts into a ResetSyncStages-deep chain; `rst_sys_n` is the last stage.
  - `rst_sys_n` goes high after edge LockCycles+1+ResetSyncStages. With default parameters that is edge 67.
- Reset mid-operation:
  - `IO_RST` high for even one edge clears everything at that edge.
  - The full sequence then restarts from edge 1 after the reset is released.
- Assertion path: there is no synchronous delay on assertion. `rst_sys_n` falls at the same edge `rst_eff` is sampled high.
- Steady state: once `rst_sys_n` = 1 it holds while `rst_eff` = 0; the counter stays saturated.

Optional Feature:
- Macro: SONATA_CLKGEN_POR_EN.
- When defined, an internal 8-bit power-on counter `por_cnt` is added.
  - Initial value 0 at configuration.
  - Increments every `IO_CLK` edge and saturates at 255.
  - `IO_RST` never clears it.
- `rst_eff` with the feature:
  - `por_cnt` < 5: `rst_eff` = 0.
  - 5 ≤ `por_cnt` < 200: `rst_eff` = 1, regardless of `IO_RST`.
  - `por_cnt` ≥ 200: `rst_eff` = `IO_RST`.
- When not defined, `por_cnt` does not exist and `rst_eff = IO_RST`.

Test Plan:
- Defaults, `IO_RST` = 1 for 5 edges then 0: `locked` rises after edge 65 counted from release, `rst_sys_n` rises after edge 67, and both hold high for 200 further edges.
- `IO_RST` pulsed high for 1 edge at edge 100 after release: `locked` and `rst_sys_n` are 0 immediately after that edge; relock completes 67 edges after the pulse ends.
- Parameters LockCycles=1, ResetSyncStages=3, release at edge 0: `locked` = 1 after edge 2, `rst_sys_n` = 1 after edge 5.
- `IO_CLK_BUF` and `clk_sys` toggle identically to `IO_CLK` with zero delta, in reset and out of reset.
- SONATA_CLKGEN_POR_EN, `IO_RST` held 0 from time 0: `rst_sys_n` stays 0; the sequence restarts when `por_cnt` reaches 200; `rst_sys_n` = 1 at edge 200+67 from configuration.
- SONATA_CLKGEN_POR_EN, `IO_RST` = 1 at edge 300: `rst_sys_n` = 0 after that edge; `por_cnt` stays at 255 and is unaffected.
